// File: rtl/modexp_io_bridge.sv
// Core-side responder for the word-serial ModExp host protocol: assembles operands, launches the core, streams the result.
// Optional build macro MODEXP_BRIDGE_ZEROIZE_EN adds a one-cycle register wipe after every result unload.
module modexp_io_bridge #(
  parameter int DATA_WIDTH = 64,
  parameter int WORDS      = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,

  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       m_in,
  input  logic [DATA_WIDTH-1:0]       e_in,
  input  logic [DATA_WIDTH-1:0]       n_in,
  input  logic [DATA_WIDTH-1:0]       r_in,
  input  logic [DATA_WIDTH-1:0]       t_in,
  input  logic [63:0]                 nprime0_in,
  output logic                        in_ready,

  output logic                        core_start,
  output logic [DATA_WIDTH*WORDS-1:0] m_op,
  output logic [DATA_WIDTH*WORDS-1:0] e_op,
  output logic [DATA_WIDTH*WORDS-1:0] n_op,
  output logic [DATA_WIDTH*WORDS-1:0] r_op,
  output logic [DATA_WIDTH*WORDS-1:0] t_op,
  output logic [63:0]                 nprime0_op,
  input  logic                        core_done,
  input  logic [DATA_WIDTH*WORDS-1:0] core_result,

  input  logic                        get_result,
  output logic                        res_avail,
  output logic                        res_valid,
  output logic [DATA_WIDTH-1:0]       res_out,
  output logic                        res_last,

  output logic                        busy,
  output logic                        overrun
);

  localparam int WIDTH = DATA_WIDTH * WORDS;
  localparam int CNT_W = 7;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_READY,
    S_UNLOAD
`ifdef MODEXP_BRIDGE_ZEROIZE_EN
    , S_ZEROIZE
`endif
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_last;
  logic               accepting;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [WIDTH-1:0]   result_q;

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign accepting = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign wr_en     = in_valid && accepting;
  // Word 0 always lands in IDLE; the counter only addresses words 1..WORDS-1.
  assign wr_idx    = (state_q == S_IDLE) ? '0 : cnt_q[IDX_W-1:0];
  assign rd_idx    = cnt_q[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_LOAD;
      S_LOAD:   if (in_valid && cnt_last) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (core_done) state_d = S_READY;
      S_READY:  if (get_result) state_d = S_UNLOAD;
      S_UNLOAD: begin
        if (cnt_last) begin
`ifdef MODEXP_BRIDGE_ZEROIZE_EN
          state_d = S_ZEROIZE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef MODEXP_BRIDGE_ZEROIZE_EN
      S_ZEROIZE: state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    res_avail  = 1'b0;
    res_valid  = 1'b0;
    res_last   = 1'b0;
    res_out    = '0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_LOAD:  in_ready   = 1'b1;
      S_START: core_start = 1'b1;
      S_READY: res_avail  = 1'b1;
      S_UNLOAD: begin
        res_valid = 1'b1;
        res_last  = cnt_last;
        res_out   = result_q[rd_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:   if (in_valid) cnt_q <= CNT_W'(1);
        S_LOAD:   if (in_valid) cnt_q <= cnt_q + CNT_W'(1);
        S_READY:  if (get_result) cnt_q <= '0;
        S_UNLOAD: cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_op       <= '0;
      e_op       <= '0;
      n_op       <= '0;
      r_op       <= '0;
      t_op       <= '0;
      nprime0_op <= '0;
      result_q   <= '0;
    end else begin
      if (wr_en) begin
        m_op[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= m_in;
        e_op[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= e_in;
        n_op[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= n_in;
        r_op[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= r_in;
        t_op[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= t_in;
        if (state_q == S_IDLE) begin
          nprime0_op <= nprime0_in;
        end
      end
      if ((state_q == S_WAIT) && core_done) begin
        result_q <= core_result;
      end
`ifdef MODEXP_BRIDGE_ZEROIZE_EN
      if (state_q == S_ZEROIZE) begin
        m_op       <= '0;
        e_op       <= '0;
        n_op       <= '0;
        r_op       <= '0;
        t_op       <= '0;
        nprime0_op <= '0;
        result_q   <= '0;
      end
`endif
    end
  end

  // Sticky: words offered while not accepting, or a completion the FSM is not waiting for.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if ((in_valid && !accepting) || (core_done && (state_q != S_WAIT))) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_modexp_io_bridge.sv
// Directed self-checking bench for modexp_io_bridge (honours MODEXP_BRIDGE_ZEROIZE_EN when defined).
module tb_modexp_io_bridge;

  localparam int DW = 64;
  localparam int NW = 64;
  localparam int W  = DW * NW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] m_in = '0, e_in = '0, n_in = '0, r_in = '0, t_in = '0;
  logic [63:0]   nprime0_in = '0;
  logic          in_ready;
  logic          core_start;
  logic [W-1:0]  m_op, e_op, n_op, r_op, t_op;
  logic [63:0]   nprime0_op;
  logic          core_done = 1'b0;
  logic [W-1:0]  core_result = '0;
  logic          get_result = 1'b0;
  logic          res_avail, res_valid, res_last, busy, overrun;
  logic [DW-1:0] res_out;

  int tests = 0;
  int fails = 0;
  int starts;
  logic [W-1:0] exp_m, exp_e, exp_n;

  always #5 clk = ~clk;

  modexp_io_bridge #(.DATA_WIDTH(DW), .WORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .m_in(m_in), .e_in(e_in), .n_in(n_in), .r_in(r_in), .t_in(t_in),
    .nprime0_in(nprime0_in), .in_ready(in_ready),
    .core_start(core_start), .m_op(m_op), .e_op(e_op), .n_op(n_op), .r_op(r_op), .t_op(t_op),
    .nprime0_op(nprime0_op), .core_done(core_done), .core_result(core_result),
    .get_result(get_result), .res_avail(res_avail), .res_valid(res_valid), .res_out(res_out),
    .res_last(res_last), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed_lo=%h expected_lo=%h differing_bits=%0d",
             tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: m=0x32 e=37 n=77 r=t=0 nprime0=1; mode 1: per-word patterns
  task automatic drive_word(input int i, input int mode);
    in_valid = 1'b1;
    if (mode == 0) begin
      m_in = (i == 0) ? 64'h32 : '0;
      e_in = (i == 0) ? 64'd37 : '0;
      n_in = (i == 0) ? 64'd77 : '0;
      r_in = '0;
      t_in = '0;
      nprime0_in = (i == 0) ? 64'h1 : 64'hDEAD_BEEF;
    end else begin
      m_in = 64'hA5A5_0000_0000_0000 | 64'(i);
      e_in = 64'h5A5A_0000_0000_0000 | 64'(i);
      n_in = ~64'(i);
      r_in = 64'(i) << 8;
      t_in = 64'(i) << 16;
      nprime0_in = (i == 0) ? 64'h77 : 64'h99;
    end
  endtask

  task automatic load(input int first, input int last, input bit gap, input int mode);
    for (int i = first; i <= last; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        m_in = '1;
        tick;
        starts += int'(core_start);
      end
      drive_word(i, mode);
      tick;
      if (i < last) starts += int'(core_start);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // ---- reset state
    repeat (2) tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_avail", res_avail, 0);
    chk("rst_overrun", overrun, 0);
    chkw("rst_m_op", m_op, '0);
    reset_n = 1'b1;
    tick;

    // ---- back-to-back load
    starts = 0;
    load(0, NW - 1, 1'b0, 0);
    chk("b2b_start_early", 64'(starts), 0);
    chk("b2b_core_start", core_start, 1);
    chkw("b2b_m_op", m_op, W'(64'h32));
    chkw("b2b_e_op", e_op, W'(64'h25));
    chkw("b2b_n_op", n_op, W'(64'h4D));
    chkw("b2b_r_op", r_op, '0);
    chkw("b2b_t_op", t_op, '0);
    chk("b2b_nprime0", nprime0_op, 64'h1);
    chk("b2b_in_ready", in_ready, 0);
    chk("b2b_busy", busy, 1);
    tick;
    chk("start_one_cycle", core_start, 0);

    // ---- stub core answers 20 cycles after launch
    starts = 0;
    repeat (19) begin
      tick;
      starts += int'(core_start);
    end
    chk("wait_no_restart", 64'(starts), 0);
    chk("wait_res_avail", res_avail, 0);
    core_done = 1'b1;
    core_result = W'(64'h8);
    tick;
    core_done = 1'b0;
    core_result = '0;
    chk("ready_res_avail", res_avail, 1);
    chk("ready_res_valid", res_valid, 0);
    chk("ready_overrun", overrun, 0);

    // get_result stays high throughout the unload
    get_result = 1'b1;
    tick;
    chk("unload_res_avail", res_avail, 0);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("res_valid[%0d]", i), res_valid, 1);
      chk($sformatf("res_out[%0d]", i), res_out, (i == 0) ? 64'h8 : 64'h0);
      chk($sformatf("res_last[%0d]", i), res_last, (i == NW - 1) ? 64'h1 : 64'h0);
      tick;
    end
    get_result = 1'b0;
    chk("post_unload_res_valid", res_valid, 0);
`ifdef MODEXP_BRIDGE_ZEROIZE_EN
    chk("zeroize_busy", busy, 1);
    tick;
    chk("post_zeroize_busy", busy, 0);
    chkw("zeroize_m_op", m_op, '0);
    chkw("zeroize_e_op", e_op, '0);
    chkw("zeroize_n_op", n_op, '0);
    chk("zeroize_nprime0", nprime0_op, 0);
`else
    chk("post_unload_busy", busy, 0);
    chkw("retain_m_op", m_op, W'(64'h32));
`endif

    // ---- load with gaps on every other cycle
    starts = 0;
    load(0, NW - 1, 1'b1, 0);
    chk("gap_start_early", 64'(starts), 0);
    chk("gap_core_start", core_start, 1);
    chkw("gap_m_op", m_op, W'(64'h32));
    chkw("gap_e_op", e_op, W'(64'h25));
    chkw("gap_n_op", n_op, W'(64'h4D));
    tick;

    // ---- in_valid during WAIT is dropped and flags overrun
    in_valid = 1'b1;
    m_in = '1;
    tick;
    in_valid = 1'b0;
    m_in = '0;
    chk("wait_drop_overrun", overrun, 1);
    chkw("wait_drop_m_op", m_op, W'(64'h32));
    chk("wait_drop_busy", busy, 1);
    repeat (3) tick;
    chk("overrun_sticky", overrun, 1);

    core_result = '0;
    core_result[63:0] = 64'h8;
    core_result[127:64] = 64'h1234;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    chk("ready2_res_avail", res_avail, 1);

    // get_result wins over a simultaneous in_valid in READY
    in_valid = 1'b1;
    m_in = '1;
    get_result = 1'b1;
    tick;
    in_valid = 1'b0;
    m_in = '0;
    get_result = 1'b0;
    chk("ready_get_wins", res_valid, 1);
    chk("ready_get_word0", res_out, 64'h8);
    chkw("ready_drop_m_op", m_op, W'(64'h32));
    chk("ready_drop_overrun", overrun, 1);
    tick;
    chk("unload2_word1", res_out, 64'h1234);
    repeat (NW - 2) tick;
    chk("unload2_last", res_last, 1);
    tick;
`ifdef MODEXP_BRIDGE_ZEROIZE_EN
    tick;
`endif
    chk("unload2_idle", busy, 0);
    chk("overrun_still_set", overrun, 1);

    // ---- reset clears overrun; core_done in IDLE sets it
    reset_n = 1'b0;
    #1;
    chk("rst_clears_overrun", overrun, 0);
    reset_n = 1'b1;
    tick;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    chk("idle_done_overrun", overrun, 1);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_res_avail", res_avail, 0);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;

    // ---- reset at word 30 of a load, then a full reload
    starts = 0;
    load(0, 29, 1'b0, 1);
    drive_word(30, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chkw("abort_m_op", m_op, '0);
    chk("abort_nprime0", nprime0_op, 0);
    in_valid = 1'b0;
    tick;
    chk("abort_no_start", core_start, 0);
    reset_n = 1'b1;
    tick;

    starts = 0;
    exp_m = '0;
    exp_e = '0;
    exp_n = '0;
    load(0, 9, 1'b0, 1);
    for (int k = 0; k < 10; k++) exp_m[k*DW +: DW] = 64'hA5A5_0000_0000_0000 | 64'(k);
    chkw("reload_partial_m_op", m_op, exp_m);
    chk("reload_partial_no_start", core_start, 0);
    load(10, NW - 1, 1'b0, 1);
    for (int k = 0; k < NW; k++) begin
      exp_m[k*DW +: DW] = 64'hA5A5_0000_0000_0000 | 64'(k);
      exp_e[k*DW +: DW] = 64'h5A5A_0000_0000_0000 | 64'(k);
      exp_n[k*DW +: DW] = ~64'(k);
    end
    chk("reload_start_early", 64'(starts), 0);
    chk("reload_core_start", core_start, 1);
    chkw("reload_m_op", m_op, exp_m);
    chkw("reload_e_op", e_op, exp_e);
    chkw("reload_n_op", n_op, exp_n);
    chk("reload_nprime0", nprime0_op, 64'h77);
    tick;
    chk("reload_start_pulse", core_start, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
